// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution instruction sequencer.
// Covers the instruction bit map, the idle instruction word and the phase enum.
package conv_seq_pkg;

  localparam int ADDR_W = 11;
  localparam int INST_W = 2*ADDR_W + 12;

  localparam int B_ACC       = 2*ADDR_W + 11;
  localparam int B_CEN_P     = 2*ADDR_W + 10;
  localparam int B_WEN_P     = 2*ADDR_W + 9;
  localparam int A_P_LSB     = ADDR_W + 9;
  localparam int B_CEN_X     = ADDR_W + 8;
  localparam int B_WEN_X     = ADDR_W + 7;
  localparam int A_X_LSB     = 7;
  localparam int B_OFIFO_RD  = 6;
  localparam int B_IFIFO_WR  = 5;
  localparam int B_IFIFO_RD  = 4;
  localparam int B_L0_RD     = 3;
  localparam int B_L0_WR     = 2;
  localparam int B_EXEC      = 1;
  localparam int B_LOAD      = 0;

  // Memories deselected with write-enable inactive; everything else quiet.
  localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << B_CEN_P) | (INST_W'(1) << B_WEN_P) |
                                            (INST_W'(1) << B_CEN_X) | (INST_W'(1) << B_WEN_X);

  typedef enum logic [3:0] {
    IDLE, CRST, W2FIFO, KLOAD, GAP, A2L0, EXEC, OFRD, ACC, DONE
  } state_e;

endpackage

// File: rtl/conv_inst_sequencer_acc_addr_gen.sv
// Accumulation read-address generator: psum address of kernel tap k for output pixel o,
// built from incrementing offsets so no multiply or divide is needed.
module acc_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int K_W   = 3,
  parameter int IN_W  = 6,
  parameter int OUT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              k_step,
  input  logic              o_step,
  output logic [ADDR_W-1:0] addr
);

  localparam int LEN_NIJ = IN_W*IN_W;

  logic [7:0]        kj_r;
  logic [7:0]        c_r;
  logic [ADDR_W-1:0] kbase_r;
  logic [ADDR_W-1:0] kofs_r;
  logic [ADDR_W-1:0] pix_r;

  assign addr = kbase_r + kofs_r + pix_r;

  // Kernel-tap and output-pixel offset counters; a pixel step restarts the kernel walk.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      kj_r    <= 8'd0;
      c_r     <= 8'd0;
      kbase_r <= '0;
      kofs_r  <= '0;
      pix_r   <= '0;
    end else if (o_step) begin
      kj_r    <= 8'd0;
      kbase_r <= '0;
      kofs_r  <= '0;
      if (c_r == 8'(OUT_W-1)) begin
        c_r   <= 8'd0;
        pix_r <= pix_r + ADDR_W'(IN_W-OUT_W+1);
      end else begin
        c_r   <= c_r + 8'd1;
        pix_r <= pix_r + ADDR_W'(1);
      end
    end else if (k_step) begin
      kbase_r <= kbase_r + ADDR_W'(LEN_NIJ);
      if (kj_r == 8'(K_W-1)) begin
        kj_r   <= 8'd0;
        kofs_r <= kofs_r + ADDR_W'(IN_W-K_W+1);
      end else begin
        kj_r   <= kj_r + 8'd1;
        kofs_r <= kofs_r + ADDR_W'(1);
      end
    end else begin
      kj_r <= kj_r;
    end
  end

endmodule

// File: rtl/conv_inst_sequencer.sv
// Weight-stationary convolution instruction sequencer: walks every kernel position,
// then accumulates each output pixel, emitting the core instruction word each cycle.
module conv_inst_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ROW       = 8,
  parameter int COL       = 8,
  parameter int K_W       = 3,
  parameter int IN_W      = 6,
  parameter int OUT_W     = 4,
  parameter int ACT_WORDS = 72,
  parameter int W_WORDS   = 16,
  parameter int WBASE     = 1024,
  parameter int RST_CYC   = 11,
  parameter int GAP_CYC   = 11
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             core_rst,
  output logic [INST_W-1:0]                inst,
  output logic                             out_strobe,
  output logic [$clog2(OUT_W*OUT_W)-1:0]   out_idx
);

  localparam int LEN_KIJ  = K_W*K_W;
  localparam int LEN_NIJ  = IN_W*IN_W;
  localparam int LEN_ONIJ = OUT_W*OUT_W;
  localparam int OIDX_W   = $clog2(LEN_ONIJ);
  localparam int T_W      = 16;

  localparam logic [T_W-1:0] T_RST    = T_W'(RST_CYC);
  localparam logic [T_W-1:0] T_WW     = T_W'(W_WORDS);
  localparam logic [T_W-1:0] T_KLOAD  = T_W'(ROW + 3*COL - 1);
  localparam logic [T_W-1:0] T_GAP    = T_W'(GAP_CYC - 1);
  localparam logic [T_W-1:0] T_ACT    = T_W'(ACT_WORDS);
  localparam logic [T_W-1:0] T_EXEC   = T_W'(ACT_WORDS + ROW + COL);
  localparam logic [T_W-1:0] T_NIJ    = T_W'(LEN_NIJ);
  localparam logic [T_W-1:0] T_RD_LO  = T_W'(2);
  localparam logic [T_W-1:0] T_RD_HI  = T_W'(LEN_KIJ + 1);
  localparam logic [T_W-1:0] T_ACC_LO = T_W'(3);
  localparam logic [T_W-1:0] T_ACC_HI = T_W'(LEN_KIJ + 2);
  localparam logic [T_W-1:0] T_KSTEP  = T_W'(LEN_KIJ);
  localparam logic [T_W-1:0] T_ACC    = T_W'(LEN_KIJ + 4);

  if (OUT_W != IN_W - K_W + 1 || WBASE + LEN_KIJ*W_WORDS > (1 << ADDR_W) ||
      LEN_KIJ*LEN_NIJ > (1 << ADDR_W) || ACT_WORDS > (1 << ADDR_W)) begin : g_cfg_check
    $error("conv_inst_sequencer: configuration does not fit the address width");
  end

  state_e            state_r;
  logic [T_W-1:0]    t_r;
  logic [7:0]        kij_r;
  logic [ADDR_W-1:0] wbase_r;
  logic [ADDR_W-1:0] pbase_r;
  logic [OIDX_W-1:0] o_r;

  logic [T_W-1:0]    last_t_s;
  logic              phase_end_s;
  logic              acc_rd_s;
  logic [ADDR_W-1:0] gen_addr_s;
  logic [INST_W-1:0] dec_inst_s;
  logic              dec_rst_s;
  logic              dec_strobe_s;

  acc_addr_gen #(.K_W(K_W), .IN_W(IN_W), .OUT_W(OUT_W)) u_acc_addr (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_r == OFRD && phase_end_s),
    .k_step (state_r == ACC && t_r >= T_RD_LO && t_r <= T_KSTEP),
    .o_step (state_r == ACC && phase_end_s),
    .addr   (gen_addr_s)
  );

  // Final in-phase cycle index for the current state.
  always_comb begin
    last_t_s = '0;
    case (state_r)
      CRST:    last_t_s = T_RST;
      W2FIFO:  last_t_s = T_WW;
      KLOAD:   last_t_s = T_KLOAD;
      GAP:     last_t_s = T_GAP;
      A2L0:    last_t_s = T_ACT;
      EXEC:    last_t_s = T_EXEC;
      OFRD:    last_t_s = T_NIJ;
      ACC:     last_t_s = T_ACC;
      default: last_t_s = '0;
    endcase
  end

  assign phase_end_s = (t_r == last_t_s);
  assign acc_rd_s    = (state_r == ACC) && (t_r >= T_RD_LO) && (t_r <= T_RD_HI);

  // Phase sequencing, kernel-position bookkeeping and the busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      t_r     <= '0;
      kij_r   <= 8'd0;
      wbase_r <= ADDR_W'(WBASE);
      pbase_r <= '0;
      o_r     <= '0;
      busy    <= 1'b0;
    end else begin
      t_r <= (state_r == IDLE || phase_end_s) ? '0 : t_r + T_W'(1);
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= CRST;
            busy    <= 1'b1;
            kij_r   <= 8'd0;
            wbase_r <= ADDR_W'(WBASE);
            pbase_r <= '0;
            o_r     <= '0;
          end
        end
        CRST:   if (phase_end_s) state_r <= W2FIFO;
        W2FIFO: if (phase_end_s) state_r <= KLOAD;
        KLOAD:  if (phase_end_s) state_r <= GAP;
        GAP:    if (phase_end_s) state_r <= A2L0;
        A2L0:   if (phase_end_s) state_r <= EXEC;
        EXEC:   if (phase_end_s) state_r <= OFRD;
        OFRD: begin
          if (phase_end_s) begin
            kij_r   <= kij_r + 8'd1;
            wbase_r <= wbase_r + ADDR_W'(W_WORDS);
            pbase_r <= pbase_r + ADDR_W'(LEN_NIJ);
            state_r <= (kij_r == 8'(LEN_KIJ-1)) ? ACC : CRST;
          end
        end
        ACC: begin
          if (phase_end_s) begin
            o_r <= o_r + OIDX_W'(1);
            if (o_r == OIDX_W'(LEN_ONIJ-1)) state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Instruction word and side-band controls for the current phase cycle.
  always_comb begin
    dec_inst_s   = INST_IDLE;
    dec_rst_s    = 1'b0;
    dec_strobe_s = 1'b0;
    case (state_r)
      CRST: dec_rst_s = (t_r < T_RST);
      W2FIFO: begin
        dec_inst_s[B_IFIFO_WR]           = 1'b1;
        dec_inst_s[B_CEN_X]              = (t_r >= T_WW);
        dec_inst_s[A_X_LSB +: ADDR_W]    = (t_r < T_WW) ? wbase_r + t_r[ADDR_W-1:0] : '0;
      end
      KLOAD: begin
        dec_inst_s[B_IFIFO_RD] = 1'b1;
        dec_inst_s[B_LOAD]     = 1'b1;
      end
      A2L0: begin
        dec_inst_s[B_L0_WR]              = 1'b1;
        dec_inst_s[B_CEN_X]              = (t_r >= T_ACT);
        dec_inst_s[A_X_LSB +: ADDR_W]    = (t_r < T_ACT) ? t_r[ADDR_W-1:0] : '0;
      end
      EXEC: begin
        dec_inst_s[B_L0_RD] = (t_r < T_EXEC);
        dec_inst_s[B_EXEC]  = (t_r < T_EXEC);
      end
      OFRD: begin
        dec_inst_s[B_OFIFO_RD]           = (t_r < T_NIJ);
        dec_inst_s[B_CEN_P]              = (t_r >= T_NIJ);
        dec_inst_s[B_WEN_P]              = (t_r >= T_NIJ);
        dec_inst_s[A_P_LSB +: ADDR_W]    = (t_r < T_NIJ) ? pbase_r + t_r[ADDR_W-1:0] : '0;
      end
      ACC: begin
        // acc trails the reads by one cycle to cover the psum read latency.
        dec_rst_s                        = (t_r == '0);
        dec_inst_s[B_CEN_P]              = !acc_rd_s;
        dec_inst_s[A_P_LSB +: ADDR_W]    = acc_rd_s ? gen_addr_s : '0;
        dec_inst_s[B_ACC]                = (t_r >= T_ACC_LO) && (t_r <= T_ACC_HI);
        dec_strobe_s                     = (t_r == T_ACC);
      end
      default: dec_inst_s = INST_IDLE;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst       <= INST_IDLE;
      core_rst   <= 1'b0;
      out_strobe <= 1'b0;
      out_idx    <= '0;
      done       <= 1'b0;
    end else begin
      inst       <= dec_inst_s;
      core_rst   <= dec_rst_s;
      out_strobe <= dec_strobe_s;
      done       <= (state_r == DONE);
      out_idx    <= dec_strobe_s ? o_r : out_idx;
    end
  end

endmodule

// File: tb/tb_conv_inst_sequencer.sv
// Bench for conv_inst_sequencer: a phase-by-phase model of the instruction stream,
// compared cycle by cycle, plus abort/restart and ignored-start scenarios.
module tb_conv_inst_sequencer;

  localparam int ROW = 8, COL = 8, K_W = 3, IN_W = 6, OUT_W = 4;
  localparam int ACT = 72, WW = 16, WBASE = 1024, RST = 11, GAP = 11;
  localparam int LEN_KIJ = K_W*K_W, LEN_NIJ = IN_W*IN_W, LEN_ONIJ = OUT_W*OUT_W;
  localparam int KIJ_CYC = (RST+1) + (WW+1) + (ROW+3*COL) + GAP + (ACT+1) + (ACT+ROW+COL+1) + (LEN_NIJ+1);
  localparam logic [33:0] IDLE_W = (34'd1 << 32) | (34'd1 << 31) | (34'd1 << 19) | (34'd1 << 18);

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, core_rst, out_strobe;
  logic [33:0] inst;
  logic [3:0]  out_idx;

  int checks = 0, errors = 0;
  int stb_n;
  logic [33:0] eq_inst[$];
  bit          eq_rst[$];
  bit          eq_stb[$];
  int          eq_idx[$];
  logic [33:0] obs_inst[$];
  bit          obs_rst[$];

  conv_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .core_rst(core_rst), .inst(inst), .out_strobe(out_strobe), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [33:0] w, input bit r, input bit s, input int idx);
    eq_inst.push_back(w); eq_rst.push_back(r); eq_stb.push_back(s); eq_idx.push_back(idx);
  endtask

  task automatic build_model();
    logic [33:0] w;
    int r, c;
    for (int kij = 0; kij < LEN_KIJ; kij++) begin
      for (int t = 0; t <= RST; t++) push(IDLE_W, t < RST, 1'b0, 0);
      for (int t = 0; t <= WW; t++) begin
        w = IDLE_W; w[5] = 1'b1;
        if (t < WW) begin w[19] = 1'b0; w[17:7] = 11'(WBASE + kij*WW + t); end
        push(w, 1'b0, 1'b0, 0);
      end
      for (int t = 0; t < ROW+3*COL; t++) begin
        w = IDLE_W; w[4] = 1'b1; w[0] = 1'b1; push(w, 1'b0, 1'b0, 0);
      end
      for (int t = 0; t < GAP; t++) push(IDLE_W, 1'b0, 1'b0, 0);
      for (int t = 0; t <= ACT; t++) begin
        w = IDLE_W; w[2] = 1'b1;
        if (t < ACT) begin w[19] = 1'b0; w[17:7] = 11'(t); end
        push(w, 1'b0, 1'b0, 0);
      end
      for (int t = 0; t < ACT+ROW+COL; t++) begin
        w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1; push(w, 1'b0, 1'b0, 0);
      end
      push(IDLE_W, 1'b0, 1'b0, 0);
      for (int t = 0; t < LEN_NIJ; t++) begin
        w = IDLE_W; w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(kij*LEN_NIJ + t);
        push(w, 1'b0, 1'b0, 0);
      end
      push(IDLE_W, 1'b0, 1'b0, 0);
    end
    for (int o = 0; o < LEN_ONIJ; o++) begin
      r = o / OUT_W; c = o % OUT_W;
      push(IDLE_W, 1'b1, 1'b0, 0);
      push(IDLE_W, 1'b0, 1'b0, 0);
      for (int k = 0; k < LEN_KIJ; k++) begin
        w = IDLE_W; w[32] = 1'b0;
        w[30:20] = 11'(k*LEN_NIJ + (r + k/K_W)*IN_W + (c + k%K_W));
        w[33] = (k >= 1);
        push(w, 1'b0, 1'b0, 0);
      end
      w = IDLE_W; w[33] = 1'b1; push(w, 1'b0, 1'b0, 0);
      push(IDLE_W, 1'b0, 1'b0, 0);
      push(IDLE_W, 1'b0, 1'b1, o);
    end
  endtask

  task automatic check_cycle(input int i);
    obs_inst.push_back(inst); obs_rst.push_back(core_rst);
    if (out_strobe === 1'b1) stb_n++;
    checks++;
    if (inst !== eq_inst[i]) begin
      errors++; $display("FAIL inst cycle %0d: got %h expected %h", i, inst, eq_inst[i]);
    end
    checks++;
    if (core_rst !== eq_rst[i]) begin
      errors++; $display("FAIL core_rst cycle %0d: got %b expected %b", i, core_rst, eq_rst[i]);
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL busy_done cycle %0d: got busy=%b done=%b expected 1/0", i, busy, done);
    end
    checks++;
    if (out_strobe !== eq_stb[i] || (eq_stb[i] && out_idx !== 4'(eq_idx[i]))) begin
      errors++; $display("FAIL strobe cycle %0d: got %b/%0d expected %b/%0d", i, out_strobe, out_idx, eq_stb[i], eq_idx[i]);
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || inst !== IDLE_W) begin
      errors++; $display("FAIL start_accept: got busy=%b inst=%h expected 1/%h", busy, inst, IDLE_W);
    end
  endtask

  task automatic follow(input int n, input bit inject);
    for (int i = 0; i < n; i++) begin
      start = inject && (i < eq_inst.size()-2) && ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
      check_cycle(i);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0 || core_rst !== 1'b0 ||
          out_strobe !== 1'b0 || out_idx !== 4'd0) begin
        errors++; $display("FAIL reset_idle %0d: got inst=%h busy=%b done=%b expected %h/0/0", i, inst, busy, done, IDLE_W);
      end
    end
  endtask

  task automatic test_full_run();
    logic [33:0] w;
    int exp5[9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};
    int bad, rise, accn, base;
    obs_inst.delete(); obs_rst.delete(); stb_n = 0;
    #($urandom_range(0, 4) * 10);
    start_run();
    follow(eq_inst.size(), 1'b1);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || inst !== IDLE_W) begin
      errors++; $display("FAIL done_pulse: got done=%b busy=%b inst=%h expected 1/0/%h", done, busy, inst, IDLE_W);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || inst !== IDLE_W) begin
      errors++; $display("FAIL done_single: got done=%b busy=%b expected 0/0", done, busy);
    end
    checks++;
    if (stb_n != LEN_ONIJ) begin
      errors++; $display("FAIL strobe_count: got %0d expected %0d", stb_n, LEN_ONIJ);
    end
    rise = -1;
    for (int i = 1; i < obs_rst.size(); i++)
      if (rise < 0 && obs_rst[i] && !obs_rst[i-1]) rise = i;
    checks++;
    if (rise != 271) begin
      errors++; $display("FAIL kij_span: got %0d expected 271", rise);
    end
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      w = obs_inst[12 + j];
      if (w[17:7] !== 11'(1024 + j) || w[19] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL w2fifo_addr: got %0d bad words expected 0", bad);
    end
    bad = 0;
    base = 2*KIJ_CYC + (KIJ_CYC - (LEN_NIJ+1));
    for (int t = 0; t < 36; t++) begin
      w = obs_inst[base + t];
      if (w[30:20] !== 11'(72 + t) || w[32:31] !== 2'b00 || w[6] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL ofrd_kij2: got %0d bad words expected 0", bad);
    end
    bad = 0; accn = 0;
    base = LEN_KIJ*KIJ_CYC + 5*14;
    for (int k = 0; k < 9; k++) begin
      w = obs_inst[base + 2 + k];
      if (w[30:20] !== 11'(exp5[k]) || w[32] !== 1'b0 || w[31] !== 1'b1) bad++;
    end
    for (int t = 0; t < 14; t++) begin
      w = obs_inst[base + t];
      if (w[33]) accn++;
    end
    w = obs_inst[base + 3];
    checks++;
    if (bad != 0 || accn != 9 || w[33] !== 1'b1) begin
      errors++; $display("FAIL acc_o5: got bad=%0d acc_cycles=%0d expected 0/9", bad, accn);
    end
  endtask

  task automatic test_abort_exec();
    int kij, off, n;
    kij = $urandom_range(0, LEN_KIJ-1);
    off = $urandom_range(0, ACT+ROW+COL-1);
    n = kij*KIJ_CYC + (RST+1) + (WW+1) + (ROW+3*COL) + GAP + (ACT+1) + off;
    obs_inst.delete(); obs_rst.delete(); stb_n = 0;
    start_run();
    follow(n, 1'b1);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0 || core_rst !== 1'b0) begin
      errors++; $display("FAIL abort: got inst=%h busy=%b done=%b expected %h/0/0", inst, busy, done, IDLE_W);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL abort_idle %0d: got inst=%h busy=%b done=%b", i, inst, busy, done);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    build_model();
    test_reset();
    test_full_run();
    test_abort_exec();
    test_full_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
